// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier feeder: FSM state encoding and error flag indices.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int ERR_SPUR = 0;
    localparam int ERR_TO   = 1;

endpackage

// File: rtl/mul_feeder_fifo.sv
// Synchronous operand FIFO with a combinational head; the caller never pushes when full or pops when empty.
module mul_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_feeder.sv
// Queues operand pairs and issues them one at a time to a multi-cycle multiplier.
// Optional WAIT-state timeout is enabled by defining MUL_FEEDER_TIMEOUT_EN.
module mul_feeder
    import mul_pkg::*;
#(
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int DEPTH     = 4,
    parameter int TO_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [M-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    output logic                   mul_vld,
    output logic [M-1:0]           mul_a,
    output logic [N-1:0]           mul_b,
    input  logic                   mul_res_vld,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             err
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mul_feeder: DEPTH must be a power of two, 2 or more");
    end
    if (TO_CYCLES < 1) begin : g_bad_timeout
        $error("mul_feeder: TO_CYCLES must be at least 1");
    end

    state_t         state;
    state_t         state_nxt;
    logic           push;
    logic           pop;
    logic [M+N-1:0] head;
    logic           to_hit;
    logic           err_spur;
    logic           err_to;

    assign in_rdy = (count < CW'(DEPTH));
    assign push   = in_vld && in_rdy;
    assign pop    = (state == ST_IDLE) && (count != '0);

    mul_feeder_fifo #(
        .DEPTH (DEPTH),
        .W     (M + N)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pop) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (mul_res_vld || to_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Operands are captured at the pop and held until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (pop) begin
            {mul_a, mul_b} <= head;
        end
    end

    assign mul_vld = (state == ST_ISSUE);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  err_spur <= 1'b0;
        else if (mul_res_vld && state != ST_WAIT) err_spur <= 1'b1;
    end

`ifdef MUL_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    // to_cnt holds the number of completed WAIT cycles; a result on the limit cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    to_cnt <= '0;
        else if (state != ST_WAIT)  to_cnt <= '0;
        else                        to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (state == ST_WAIT) && !mul_res_vld && (to_cnt == TW'(TO_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err_to <= 1'b0;
        else if (to_hit) err_to <= 1'b1;
    end
`else
    assign to_hit = 1'b0;
    assign err_to = 1'b0;
`endif

    assign err[ERR_SPUR] = err_spur;
    assign err[ERR_TO]   = err_to;

endmodule

// File: tb/tb_mul_feeder.sv
// Self-checking bench for mul_feeder: a transaction-level model checked every cycle plus directed literal checks.
module tb_mul_feeder;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [M-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          mul_vld;
    logic [M-1:0]  mul_a;
    logic [N-1:0]  mul_b;
    logic          mul_res_vld;
    logic          busy;
    logic [CW-1:0] count;
    logic [1:0]    err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_feeder #(
        .M         (M),
        .N         (N),
        .DEPTH     (DEPTH),
        .TO_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_vld     (mul_vld),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_res_vld (mul_res_vld),
        .busy        (busy),
        .count       (count),
        .err         (err)
    );

    // Transaction model: a queue of pairs, one outstanding multiply, and the earliest edge a new issue may occur.
    logic [M+N-1:0] mq[$];
    logic [M+N-1:0] seen[$];
    bit             outstanding = 0;
    int             issue_edge  = 0;
    int             ready_edge  = 0;
    int             cyc         = 0;
    logic           exp_vld     = 1'b0;
    logic [M-1:0]   exp_a       = '0;
    logic [N-1:0]   exp_b       = '0;
    logic [1:0]     exp_err     = 2'b00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic stepModel();
        int sz;
        bit issue;
        bit res_ok;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            outstanding = 0;
            ready_edge  = 0;
            exp_vld     = 1'b0;
            exp_a       = '0;
            exp_b       = '0;
            exp_err     = 2'b00;
        end else begin
            issue   = !outstanding && (cyc >= ready_edge) && (sz > 0);
            res_ok  = outstanding && (cyc >= issue_edge + 2);
            exp_vld = 1'b0;
            if (mul_res_vld) begin
                if (res_ok) begin
                    outstanding = 0;
                    ready_edge  = cyc + 1;
                end else begin
                    exp_err[0] = 1'b1;
                end
            end
`ifdef MUL_FEEDER_TIMEOUT_EN
            else if (res_ok && cyc == issue_edge + 1 + TO) begin
                outstanding = 0;
                ready_edge  = cyc + 1;
                exp_err[1]  = 1'b1;
            end
`endif
            if (issue) begin
                {exp_a, exp_b} = mq.pop_front();
                exp_vld     = 1'b1;
                outstanding = 1;
                issue_edge  = cyc;
            end
            if (in_vld && sz < DEPTH) mq.push_back({in_a, in_b});
        end
        cyc++;
    endtask

    // Compare process: update the model on the edge, compare 1 time unit later.
    always @(posedge clk) begin
        stepModel();
        #1;
        checkOutput("mul_vld", mul_vld, exp_vld);
        checkOutput("mul_a",   mul_a,   exp_a);
        checkOutput("mul_b",   mul_b,   exp_b);
        checkOutput("busy",    busy,    outstanding);
        checkOutput("count",   count,   mq.size());
        checkOutput("in_rdy",  in_rdy,  mq.size() < DEPTH);
        checkOutput("err",     err,     exp_err);
        if (mul_vld) seen.push_back({mul_a, mul_b});
    end

    task automatic applyStimulus(input bit vld, input logic [M-1:0] a, input logic [N-1:0] b, input bit res);
        in_vld      = vld;
        in_a        = a;
        in_b        = b;
        mul_res_vld = res;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((count != '0 || busy) && n < 80) begin
            applyStimulus(1'b0, '0, '0, busy && !mul_vld);
            n++;
        end
        checkOutput("drain_bound", n < 80, 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_vld      = 1'b0;
        in_a        = '0;
        in_b        = '0;
        mul_res_vld = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_rdy",   in_rdy, 1);
        checkOutput("rst_vld",   mul_vld, 0);
        checkOutput("rst_busy",  busy, 0);
        checkOutput("rst_err",   err, 0);
        checkOutput("rst_ab",    {mul_a, mul_b}, 0);
        rst = 1'b0;
        idle(2);

        $display("[TB] single pair");
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0);
        checkOutput("single_cnt1", count, 1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("single_vld", mul_vld, 1);
        checkOutput("single_ab", {mul_a, mul_b}, 8'h35);
        checkOutput("single_busy_issue", busy, 1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("single_vld_off", mul_vld, 0);
        checkOutput("single_busy_wait", busy, 1);
        idle(3);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("single_idle", busy, 0);
        checkOutput("single_err", err, 0);
        checkOutput("single_hold_ab", {mul_a, mul_b}, 8'h35);

        $display("[TB] spurious result");
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("spur_err", err, 2'b01);
        checkOutput("spur_busy", busy, 0);
        checkOutput("spur_vld", mul_vld, 0);
        idle(2);
        doReset();
        checkOutput("spur_clear", err, 0);

        $display("[TB] fill");
        seen.delete();
        for (int i = 1; i <= 5; i++) begin
            checkOutput($sformatf("fill_rdy%0d", i), in_rdy, 1);
            applyStimulus(1'b1, 4'(i), 4'(i + 8), 1'b0);
        end
        checkOutput("fill_full_cnt", count, 4);
        checkOutput("fill_full_rdy", in_rdy, 0);
        applyStimulus(1'b1, 4'd6, 4'd14, 1'b0);
        applyStimulus(1'b1, 4'd6, 4'd14, 1'b0);
        checkOutput("fill_held_cnt", count, 4);
        applyStimulus(1'b1, 4'd6, 4'd14, 1'b1);
        applyStimulus(1'b1, 4'd6, 4'd14, 1'b0);
        checkOutput("fill_no_bypass", count, 3);
        applyStimulus(1'b1, 4'd6, 4'd14, 1'b0);
        checkOutput("fill_accept6", count, 4);
        in_vld = 1'b0;
        drain();
        checkOutput("fill_order_len", seen.size(), 6);
        for (int i = 1; i <= 6 && i <= seen.size(); i++)
            checkOutput($sformatf("fill_order%0d", i), seen[i-1], {4'(i), 4'(i + 8)});

        $display("[TB] same-edge push and pop");
        seen.delete();
        applyStimulus(1'b1, 4'd7, 4'd1, 1'b0);
        applyStimulus(1'b1, 4'd8, 4'd2, 1'b0);
        applyStimulus(1'b1, 4'd9, 4'd3, 1'b0);
        idle(1);
        checkOutput("same_pre_cnt", count, 2);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 4'd10, 4'd4, 1'b0);
        checkOutput("same_cnt", count, 2);
        checkOutput("same_issue", {mul_vld, mul_a, mul_b}, 9'h182);
        in_vld = 1'b0;
        drain();
        checkOutput("same_order_len", seen.size(), 4);
        if (seen.size() == 4) begin
            checkOutput("same_order0", seen[0], 8'h71);
            checkOutput("same_order3", seen[3], 8'hA4);
        end

        $display("[TB] reset mid-wait");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 4'(i), 1'b0);
        in_vld = 1'b0;
        checkOutput("midrst_pre_cnt", count, 3);
        checkOutput("midrst_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_cnt", count, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_vld", mul_vld, 0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        seen.delete();
        idle(10);
        checkOutput("midrst_quiet", seen.size(), 0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("midrst_late_res", err, 2'b01);
        doReset();

        $display("[TB] withheld result");
        applyStimulus(1'b1, 4'd5, 4'd5, 1'b0);
        in_vld = 1'b0;
`ifdef MUL_FEEDER_TIMEOUT_EN
        idle(TO + 3);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_err", err, 2'b10);
`else
        idle(100);
        checkOutput("noto_busy", busy, 1);
        checkOutput("noto_err", err, 2'b00);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("noto_done", busy, 0);
`endif
        doReset();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
